// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue/query/writeback/commit bundle of the reorder buffer
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 4
);
  // issue side
  logic                 issue;
  logic [1:0]           issue_type;
  logic [4:0]           issue_rd;
  logic                 issue_pred_taken;
  logic [31:0]          issue_alt_pc;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 full;

  // operand-tag queries
  logic [ROB_WIDTH-1:0] query_tag_1;
  logic [ROB_WIDTH-1:0] query_tag_2;
  logic                 query_ready_1;
  logic                 query_ready_2;
  logic [31:0]          query_value_1;
  logic [31:0]          query_value_2;

  // writeback strobes
  logic                 done_alu_1;
  logic                 done_alu_2;
  logic                 done_lsb;
  logic [31:0]          value_alu_1;
  logic [31:0]          value_alu_2;
  logic [31:0]          value_lsb;
  logic [ROB_WIDTH-1:0] tag_alu_1;
  logic [ROB_WIDTH-1:0] tag_alu_2;
  logic [ROB_WIDTH-1:0] tag_lsb;

  // commit and flush
  logic                 commit_valid;
  logic [ROB_WIDTH-1:0] commit_tag;
  logic [4:0]           commit_rd;
  logic [31:0]          commit_value;
  logic                 commit_store;
  logic                 clear_signal;
  logic [31:0]          clear_pc;

  modport master (
    output issue, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output query_tag_1, query_tag_2,
    output done_alu_1, done_alu_2, done_lsb,
    output value_alu_1, value_alu_2, value_lsb,
    output tag_alu_1, tag_alu_2, tag_lsb,
    input  issue_tag, full,
    input  query_ready_1, query_ready_2, query_value_1, query_value_2,
    input  commit_valid, commit_tag, commit_rd, commit_value, commit_store,
    input  clear_signal, clear_pc
  );

  modport slave (
    input  issue, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  query_tag_1, query_tag_2,
    input  done_alu_1, done_alu_2, done_lsb,
    input  value_alu_1, value_alu_2, value_lsb,
    input  tag_alu_1, tag_alu_2, tag_lsb,
    output issue_tag, full,
    output query_ready_1, query_ready_2, query_value_1, query_value_2,
    output commit_valid, commit_tag, commit_rd, commit_value, commit_store,
    output clear_signal, clear_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with branch mispredict flush
module reorder_buffer #(
  parameter int ROB_WIDTH = 4,
  parameter int ROB_SIZE  = 2 ** ROB_WIDTH
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave bus
);
  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_STORE  = 2'd2;
  localparam logic [ROB_WIDTH:0] COUNT_FULL = (ROB_WIDTH + 1)'(ROB_SIZE);

  typedef logic [ROB_WIDTH-1:0] tag_t;

  tag_t                head;
  tag_t                tail;
  logic [ROB_WIDTH:0]  count;
  logic [ROB_SIZE-1:0] busy;
  logic [ROB_SIZE-1:0] ready;
  logic [ROB_SIZE-1:0] ent_pred;
  logic [1:0]          ent_type   [ROB_SIZE];
  logic [4:0]          ent_rd     [ROB_SIZE];
  logic [31:0]         ent_value  [ROB_SIZE];
  logic [31:0]         ent_alt_pc [ROB_SIZE];

  logic                commit_valid_q;
  tag_t                commit_tag_q;
  logic [4:0]          commit_rd_q;
  logic [31:0]         commit_value_q;
  logic                commit_store_q;
  logic                clear_signal_q;
  logic [31:0]         clear_pc_q;

  logic                issue_ok;
  logic                commit_ok;
  logic                wb_en;
  logic                head_mispredict;
  logic [ROB_SIZE-1:0] wb_hit;
  logic [31:0]         wb_value [ROB_SIZE];

  assign bus.full         = (count == COUNT_FULL);
  assign bus.issue_tag    = tail;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_value = commit_value_q;
  assign bus.commit_store = commit_store_q;
  assign bus.clear_signal = clear_signal_q;
  assign bus.clear_pc     = clear_pc_q;

  // Queries read the stored state only; same-cycle strobes are forwarded by the RS.
  assign bus.query_ready_1 = busy[bus.query_tag_1] & ready[bus.query_tag_1];
  assign bus.query_ready_2 = busy[bus.query_tag_2] & ready[bus.query_tag_2];
  assign bus.query_value_1 = ent_value[bus.query_tag_1];
  assign bus.query_value_2 = ent_value[bus.query_tag_2];

  // While a flush is pending nothing is allocated, retired or captured.
  assign issue_ok  = rdy_in & bus.issue & ~bus.full & ~clear_signal_q;
  assign commit_ok = rdy_in & busy[head] & ready[head] & ~clear_signal_q;
  assign wb_en     = rdy_in & ~clear_signal_q;

  // A branch's resolved direction lives in bit 0 of its result.
  assign head_mispredict = (ent_type[head] == TYPE_BRANCH) &
                           (ent_value[head][0] != ent_pred[head]);

  // Per-entry writeback match; ALU1 beats ALU2 beats LSB on a shared tag.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      wb_hit[i]   = 1'b0;
      wb_value[i] = '0;
      if (wb_en && busy[i] && !ready[i]) begin
        if (bus.done_alu_1 && bus.tag_alu_1 == tag_t'(i)) begin
          wb_hit[i]   = 1'b1;
          wb_value[i] = bus.value_alu_1;
        end else if (bus.done_alu_2 && bus.tag_alu_2 == tag_t'(i)) begin
          wb_hit[i]   = 1'b1;
          wb_value[i] = bus.value_alu_2;
        end else if (bus.done_lsb && bus.tag_lsb == tag_t'(i)) begin
          wb_hit[i]   = 1'b1;
          wb_value[i] = bus.value_lsb;
        end
      end
    end
  end

  // Control state: pointers, occupancy flags, commit and flush pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_store_q <= 1'b0;
      clear_signal_q <= 1'b0;
      clear_pc_q     <= '0;
    end else if (rdy_in) begin
      if (clear_signal_q) begin
        head           <= '0;
        tail           <= '0;
        count          <= '0;
        busy           <= '0;
        ready          <= '0;
        commit_valid_q <= 1'b0;
        commit_store_q <= 1'b0;
        clear_signal_q <= 1'b0;
      end else begin
        ready          <= ready | wb_hit;
        commit_valid_q <= commit_ok;
        commit_store_q <= commit_ok & (ent_type[head] == TYPE_STORE);
        clear_signal_q <= commit_ok & head_mispredict;
        if (commit_ok) begin
          busy[head]     <= 1'b0;
          ready[head]    <= 1'b0;
          head           <= head + 1'b1;
          commit_tag_q   <= head;
          commit_rd_q    <= ent_rd[head];
          commit_value_q <= ent_value[head];
          if (head_mispredict) begin
            clear_pc_q <= ent_alt_pc[head];
          end
        end
        if (issue_ok) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        count <= count + (ROB_WIDTH + 1)'(issue_ok) - (ROB_WIDTH + 1)'(commit_ok);
      end
    end
  end

  // Entry payload; validity is carried by busy/ready so no reset is needed here.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (wb_hit[i]) begin
        ent_value[i] <= wb_value[i];
      end
    end
    if (issue_ok) begin
      ent_type[tail]   <= bus.issue_type;
      ent_rd[tail]     <= (bus.issue_type == TYPE_REG) ? bus.issue_rd : 5'd0;
      ent_pred[tail]   <= bus.issue_pred_taken;
      ent_alt_pc[tail] <= bus.issue_alt_pc;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized checks of reorder_buffer against a queue model
module tb_reorder_buffer;
  localparam int W = 4;
  localparam int N = 16;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reorder_buffer_if #(.ROB_WIDTH(W)) rif ();

  reorder_buffer #(.ROB_WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (rif)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          rdy;
    bit          pred;
    logic [31:0] alt;
  } ent_t;

  ent_t        rob_q[$];
  int          m_tail;
  bit          m_cv, m_cs, m_clear;
  logic [3:0]  m_ctag;
  logic [4:0]  m_crd;
  logic [31:0] m_cval, m_cpc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pause_commits;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic int find(input logic [3:0] t);
    foreach (rob_q[i]) if (rob_q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    rob_q.delete();
    m_tail = 0; m_cv = 0; m_cs = 0; m_clear = 0;
    m_ctag = '0; m_crd = '0; m_cval = '0; m_cpc = '0;
  endtask

  task automatic m_wb(input logic d, input logic [3:0] t, input logic [31:0] v);
    int k;
    ent_t e;
    if (!d) return;
    k = find(t);
    if (k >= 0 && !rob_q[k].rdy) begin
      e = rob_q[k]; e.val = v; e.rdy = 1; rob_q[k] = e;
    end
  endtask

  // One active edge of the reference model, evaluated on pre-edge state.
  task automatic model_edge();
    bit   do_commit, do_issue;
    ent_t h, e;
    if (m_clear) begin
      rob_q.delete();
      m_tail = 0; m_clear = 0; m_cv = 0; m_cs = 0;
      return;
    end
    do_commit = rob_q.size() > 0 && rob_q[0].rdy;
    do_issue  = rif.issue && rob_q.size() < N;
    if (do_commit) h = rob_q[0];
    m_wb(rif.done_alu_1, rif.tag_alu_1, rif.value_alu_1);
    m_wb(rif.done_alu_2, rif.tag_alu_2, rif.value_alu_2);
    m_wb(rif.done_lsb,   rif.tag_lsb,   rif.value_lsb);
    m_cv = do_commit; m_cs = 0;
    if (do_commit) begin
      void'(rob_q.pop_front());
      m_ctag = h.tag;
      m_crd  = (h.typ == 2'd0) ? h.rd : 5'd0;
      m_cval = h.val;
      m_cs   = (h.typ == 2'd2);
      if (h.typ == 2'd1 && h.val[0] != h.pred) begin
        m_clear = 1; m_cpc = h.alt;
      end
    end
    if (do_issue) begin
      e.tag = 4'(m_tail); e.typ = rif.issue_type; e.rd = rif.issue_rd; e.val = '0;
      e.rdy = 0; e.pred = rif.issue_pred_taken; e.alt = rif.issue_alt_pc;
      rob_q.push_back(e);
      m_tail = (m_tail + 1) % N;
    end
  endtask

  task automatic chk_query(input string name, input logic [3:0] t, input logic r, input logic [31:0] v);
    int k;
    bit exp_r;
    k = find(t);
    exp_r = (k >= 0) && rob_q[k].rdy;
    chk({name, "_ready"}, 32'(r), 32'(exp_r));
    if (exp_r) chk({name, "_value"}, v, rob_q[k].val);
  endtask

  task automatic check_all();
    chk("issue_tag", 32'(rif.issue_tag), 32'(m_tail));
    chk("full", 32'(rif.full), 32'(rob_q.size() == N));
    chk("commit_valid", 32'(rif.commit_valid), 32'(m_cv));
    chk("commit_store", 32'(rif.commit_store), 32'(m_cs));
    chk("clear_signal", 32'(rif.clear_signal), 32'(m_clear));
    if (m_cv) begin
      chk("commit_tag", 32'(rif.commit_tag), 32'(m_ctag));
      chk("commit_rd", 32'(rif.commit_rd), 32'(m_crd));
      if (!m_cs) chk("commit_value", rif.commit_value, m_cval);
    end
    if (m_clear) chk("clear_pc", rif.clear_pc, m_cpc);
    chk_query("query1", rif.query_tag_1, rif.query_ready_1, rif.query_value_1);
    chk_query("query2", rif.query_tag_2, rif.query_ready_2, rif.query_value_2);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    if (rdy_in && rst_in) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rif.issue = 0; rif.done_alu_1 = 0; rif.done_alu_2 = 0; rif.done_lsb = 0;
  endtask

  task automatic issue_one(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] alt);
    rif.issue = 1; rif.issue_type = t; rif.issue_rd = rd;
    rif.issue_pred_taken = p; rif.issue_alt_pc = alt;
    cyc();
    rif.issue = 0;
  endtask

  task automatic wb1(input logic [3:0] t, input logic [31:0] v);
    rif.done_alu_1 = 1; rif.tag_alu_1 = t; rif.value_alu_1 = v;
    cyc();
    rif.done_alu_1 = 0;
  endtask

  task automatic async_reset();
    #2 rst_in = 0;
    #1;
    chk("rst_issue_tag", 32'(rif.issue_tag), 32'd0);
    chk("rst_full", 32'(rif.full), 32'd0);
    chk("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
    chk("rst_clear_signal", 32'(rif.clear_signal), 32'd0);
    chk("rst_commit_store", 32'(rif.commit_store), 32'd0);
    chk("rst_commit_value", rif.commit_value, 32'd0);
    chk("rst_clear_pc", rif.clear_pc, 32'd0);
    chk("rst_query_ready", 32'(rif.query_ready_1), 32'd0);
    model_reset();
    @(posedge clk_in);
    #1 rst_in = 1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 0; rdy_in = 1;
    idle();
    rif.issue_type = 0; rif.issue_rd = 0; rif.issue_pred_taken = 0; rif.issue_alt_pc = 0;
    rif.query_tag_1 = 0; rif.query_tag_2 = 0;
    rif.tag_alu_1 = 0; rif.tag_alu_2 = 0; rif.tag_lsb = 0;
    rif.value_alu_1 = 0; rif.value_alu_2 = 0; rif.value_lsb = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1;
    check_all();
    chk("reset_commit_tag", 32'(rif.commit_tag), 32'd0);
    chk("reset_commit_rd", 32'(rif.commit_rd), 32'd0);

    // In-order commit despite out-of-order completion.
    issue_one(2'd0, 5'd5, 0, 0);
    issue_one(2'd0, 5'd6, 0, 0);
    rif.done_alu_2 = 1; rif.tag_alu_2 = 1; rif.value_alu_2 = 32'h22; rif.query_tag_2 = 1;
    cyc();
    rif.done_alu_2 = 0;
    wb1(4'd0, 32'h11);
    cyc();
    chk("inorder_c0_tag", 32'(rif.commit_tag), 32'd0);
    chk("inorder_c0_rd", 32'(rif.commit_rd), 32'd5);
    chk("inorder_c0_value", rif.commit_value, 32'h11);
    cyc();
    chk("inorder_c1_valid", 32'(rif.commit_valid), 32'd1);
    chk("inorder_c1_tag", 32'(rif.commit_tag), 32'd1);
    chk("inorder_c1_rd", 32'(rif.commit_rd), 32'd6);
    chk("inorder_c1_value", rif.commit_value, 32'h22);
    cyc();

    // Writeback priority on a shared tag.
    issue_one(2'd0, 5'd1, 0, 0);
    issue_one(2'd0, 5'd2, 0, 0);
    rif.done_alu_1 = 1; rif.tag_alu_1 = 3; rif.value_alu_1 = 7;
    rif.done_lsb = 1; rif.tag_lsb = 3; rif.value_lsb = 9; rif.query_tag_1 = 3;
    cyc();
    idle();
    chk("prio_ready", 32'(rif.query_ready_1), 32'd1);
    chk("prio_value", rif.query_value_1, 32'd7);
    rif.done_alu_2 = 1; rif.tag_alu_2 = 2; rif.value_alu_2 = 2;
    cyc();
    idle();
    repeat (3) cyc();

    // Asynchronous reset with three live entries.
    issue_one(2'd0, 5'd3, 0, 0);
    issue_one(2'd2, 5'd3, 0, 0);
    issue_one(2'd1, 5'd3, 1, 32'h40);
    rif.query_tag_1 = 4;
    async_reset();

    // Mispredicted branch at tag 2 with younger entries in flight.
    issue_one(2'd0, 5'd1, 0, 0);
    issue_one(2'd0, 5'd2, 0, 0);
    rif.done_alu_1 = 1; rif.tag_alu_1 = 0; rif.value_alu_1 = 1;
    rif.done_alu_2 = 1; rif.tag_alu_2 = 1; rif.value_alu_2 = 2;
    cyc();
    idle();
    issue_one(2'd1, 5'd9, 0, 32'h100);
    issue_one(2'd0, 5'd3, 0, 0);
    issue_one(2'd0, 5'd4, 0, 0);
    issue_one(2'd0, 5'd5, 0, 0);
    wb1(4'd2, 32'd1);
    rif.query_tag_1 = 3;
    cyc();
    chk("mis_clear", 32'(rif.clear_signal), 32'd1);
    chk("mis_clear_pc", rif.clear_pc, 32'h100);
    chk("mis_commit_tag", 32'(rif.commit_tag), 32'd2);
    rif.issue = 1; rif.issue_type = 0; rif.issue_rd = 8;
    cyc();
    rif.issue = 0;
    chk("mis_flush_clear", 32'(rif.clear_signal), 32'd0);
    chk("mis_flush_tag", 32'(rif.issue_tag), 32'd0);
    chk("mis_flush_ready3", 32'(rif.query_ready_1), 32'd0);
    cyc();

    // Fill, reject the 17th issue, free tag 0 and reuse it across the wrap.
    for (int i = 0; i < N; i++) issue_one(2'd0, 5'(i + 1), 0, 0);
    chk("full_after_16", 32'(rif.full), 32'd1);
    issue_one(2'd0, 5'd20, 0, 0);
    chk("full_17th_ignored", 32'(rif.full), 32'd1);
    chk("full_17th_tag", 32'(rif.issue_tag), 32'd0);
    wb1(4'd0, 32'hAA);
    cyc();
    chk("wrap_commit_tag", 32'(rif.commit_tag), 32'd0);
    chk("wrap_not_full", 32'(rif.full), 32'd0);
    issue_one(2'd0, 5'd9, 0, 0);
    chk("wrap_tag_after", 32'(rif.issue_tag), 32'd1);
    chk("wrap_full_again", 32'(rif.full), 32'd1);
    async_reset();

    // Pause with a commit pulse on the outputs.
    issue_one(2'd0, 5'd7, 0, 0);
    wb1(4'd0, 32'h77);
    cyc();
    pause_commits = 0;
    if (rif.commit_valid) pause_commits++;
    rdy_in = 0;
    rif.issue = 1; rif.done_alu_1 = 1; rif.tag_alu_1 = 1; rif.value_alu_1 = 5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pause_valid_held", 32'(rif.commit_valid), 32'd1);
      chk("pause_tag_held", 32'(rif.commit_tag), 32'd0);
      chk("pause_tail_held", 32'(rif.issue_tag), 32'd1);
    end
    idle();
    rdy_in = 1;
    cyc();
    if (rif.commit_valid) pause_commits++;
    chk("pause_one_commit", 32'(pause_commits), 32'd1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      rdy_in               = ($urandom_range(0, 7) != 0);
      rif.issue            = $urandom_range(0, 1);
      rif.issue_type       = 2'($urandom_range(0, 2));
      rif.issue_rd         = 5'($urandom);
      rif.issue_pred_taken = $urandom_range(0, 1);
      rif.issue_alt_pc     = $urandom;
      rif.done_alu_1       = ($urandom_range(0, 9) < 4);
      rif.done_alu_2       = ($urandom_range(0, 9) < 4);
      rif.done_lsb         = ($urandom_range(0, 9) < 4);
      rif.value_alu_1      = $urandom;
      rif.value_alu_2      = $urandom;
      rif.value_lsb        = $urandom;
      if (rob_q.size() > 0 && $urandom_range(0, 4) != 0) begin
        rif.tag_alu_1   = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
        rif.tag_alu_2   = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
        rif.tag_lsb     = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
        rif.query_tag_1 = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
      end else begin
        rif.tag_alu_1   = 4'($urandom);
        rif.tag_alu_2   = 4'($urandom);
        rif.tag_lsb     = 4'($urandom);
        rif.query_tag_1 = 4'($urandom);
      end
      rif.query_tag_2 = 4'($urandom);
      cyc();
    end
    idle();
    rdy_in = 1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue for the out-of-order core, sitting directly upstream of the reservation station. At issue it allocates the destination tag (`rd_issue_tag`) and answers operand-tag queries (`rs_issue_value/valid`). It captures results from ALU1, ALU2 and the LSB, then commits one entry per cycle to the register file and LSB. It raises the `clear_signal` that flushes the reservation station on a branch misprediction.

## Interface
- `ROB_WIDTH`, 4: tag width.
- `ROB_SIZE`, 2**ROB_WIDTH: number of entries.

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  pause when low
- `issue`  in  1  allocate entry at tail
- `issue_type`  in  2  0 = REG, 1 = BRANCH, 2 = STORE
- `issue_rd`  in  5  destination register (ignored unless REG)
- `issue_pred_taken`  in  1  predicted direction (BRANCH)
- `issue_alt_pc`  in  32  redirect PC if the prediction is wrong
- `issue_tag`  out  ROB_WIDTH  tag of current tail; becomes `rd_issue_tag`
- `full`  out  1  no free entry
- `query_tag_1`, `query_tag_2`  in  ROB_WIDTH  operand tags
- `query_ready_1`, `query_ready_2`  out  1  entry busy and result captured
- `query_value_1`, `query_value_2`  out  32  captured result
- `done_alu_1`, `done_alu_2`, `done_lsb`  in  1  writeback strobes
- `value_alu_1`, `value_alu_2`, `value_lsb`  in  32  writeback values
- `tag_alu_1`, `tag_alu_2`, `tag_lsb`  in  ROB_WIDTH  writeback tags
- `commit_valid`  out  1  one-cycle commit pulse
- `commit_tag`  out  ROB_WIDTH  tag of committed entry
- `commit_rd`  out  5  destination register (0 for BRANCH/STORE)
- `commit_value`  out  32  result value
- `commit_store`  out  1  committed entry is a STORE; LSB may perform it
- `clear_signal`  out  1  misprediction flush pulse
- `clear_pc`  out  32  fetch redirect PC

## Operation
**Storage**
- Circular buffer with `head`, `tail` (ROB_WIDTH bits, wrap modulo ROB_SIZE) and `count` (ROB_WIDTH+1 bits).
- Per entry: busy, ready, type, rd, value, pred_taken, alt_pc.
- `full = (count == ROB_SIZE)`.
- `issue_tag = tail`.

**Issue**
- Condition: `issue & ~full & ~clear_signal`.
- Write the entry at `tail` with busy=1 and ready=0; `tail++`.
- Issue while `full` or during `clear_signal` is ignored.

**Writeback**
- For each strobe, if the target entry is busy and not ready: store the value and set ready=1.
- Same tag on several strobes: priority ALU1 > ALU2 > LSB.
- STORE entries become ready via an LSB strobe (address resolved); the value is ignored.
- Writeback to a non-busy entry is ignored.

**Query**
- Combinational read: `ready = busy & ready`, `value = value`.
- Query does not forward same-cycle writeback strobes; the reservation station does that itself.

**Commit**
- Condition: head entry busy & ready & `~clear_signal`.
- Register on the edge: `commit_valid=1`, tag, rd, value, `commit_store=(type==STORE)`.
- Clear head busy; `head++`.
- BRANCH entry: actual taken = `value[0]`.
  - If it differs from `pred_taken`: also register `clear_signal=1` and `clear_pc=alt_pc`.
- All pulse outputs return to 0 on the next active edge unless re-asserted.

**Flush**
- On an edge with `rdy_in & clear_signal`: clear all busy/ready bits; head=tail=count=0; deassert `clear_signal`.
- This is the same edge on which the reservation station clears.

**Count update**
- `count += issue_accepted - commit_accepted`.
- Simultaneous issue and commit leaves count unchanged.

**Pause**
- `rdy_in` low: all registers, including pulse outputs, hold.
- Consumers sample pulses only when `rdy_in` is high.

**Reset**
- `rst_in` low, asynchronous: head=tail=count=0; all busy=0.
- Outputs: `commit_valid=0`, `commit_store=0`, `clear_signal=0`, `commit_tag=0`, `commit_rd=0`, `commit_value=0`, `clear_pc=0`.
- Reset mid-operation discards all entries immediately.

## Timing
- Issue → visible as a busy entry at the next edge; `issue_tag` advances the same edge.
- Writeback at edge N → `query_ready` high after edge N; commit earliest at edge N+1; `commit_valid` visible for the cycle after N+1.
- Issue to commit is at least 2 edges.
- Commit throughput: 1 entry/cycle.
- Mispredict:
  - Commit edge C raises `clear_signal`.
  - Flush edge C+1 deasserts it; issue and commit are blocked in that cycle.
  - Empty, tag 0, at C+1.
- `full` is combinational from `count`; a slot freed by commit is usable the cycle after.

## Test plan
- **Reset:** hold `rst_in`=0 mid-run with 3 entries busy → `count`=0, `issue_tag`=0, `commit_valid`=0, `clear_signal`=0 immediately (asynchronous).
- **In-order commit:** issue REG rd=5 (tag 0) and REG rd=6 (tag 1); `done_alu_2` tag 1 value 0x22; then `done_alu_1` tag 0 value 0x11 → commits tag 0 (rd 5, 0x11) then tag 1 (rd 6, 0x22) on consecutive cycles.
- **Full/wrap:** issue 16 entries → `full`=1 and a 17th issue is ignored. Complete and commit tag 0, then issue → new entry gets tag 0; `tail` wraps 15→0.
- **Writeback priority:** `done_alu_1` tag 3 value 7 and `done_lsb` tag 3 value 9 in the same cycle → `query_value` for tag 3 = 7.
- **Mispredict:** BRANCH with pred_taken=0, alt_pc=0x100, tag 2 (tags 0–1 committed); ALU returns 1 while tags 3–5 are busy → `clear_signal`=1, `clear_pc`=0x100 for one cycle; next cycle `count`=0, `issue_tag`=0.
- **Pause:** `rdy_in` low for 3 cycles with `commit_valid`=1 → output held, head unchanged; exactly one commit counted after `rdy_in` returns high.
